writeback: RTL and testbench

WRITEBACK -- requirements
Module: writeback

---
 rtl/writeback_pkg.sv | 31 +++
 rtl/wb_fifo.sv | 66 ++++++
 rtl/writeback.sv | 125 ++++++++++++
 tb/tb_writeback.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
// Shared wires package for the writeback stage.
// Holds register address/data widths, the buffered long-result entry layout
// and the writeback-to-register-file field mapping (register_in_type).
package writeback_pkg;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ENTRY_W = REG_AW + DATA_W;

    // One buffered result: destination register and value (37 bits).
    typedef struct packed {
        logic [REG_AW-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } wb_entry_t;

    // Register-file write port as seen by the register file.
    typedef struct packed {
        logic              wren;
        logic [REG_AW-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } register_in_type;

    function automatic register_in_type wb_to_reg(input logic wren, input wb_entry_t e);
        register_in_type r;
        r.wren  = wren;
        r.waddr = e.waddr;
        r.wdata = e.wdata;
        return r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Long-latency result buffer.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   push, din      enqueue din (caller never pushes when full)
//   pop, dout      dequeue; dout is the current head
//   empty          no entries buffered
//   avail          registered "count < DEPTH", used directly as lng_ready
module wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             avail
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             avail_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            avail_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
            // Registered from next count so lng_ready has no path from lng_valid.
            avail_q <= (count_d < CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= din;
    end

    assign dout  = mem[rd_ptr_q];
    assign empty = (count_q == '0);
    assign avail = avail_q;

endmodule

// File: rtl/writeback.sv
// Writeback stage: merges single-cycle exe results and buffered long-latency
// results onto one registered register-file write port, tracks pending long
// destinations for decode stalls, and forwards the registered write to decode.
// Ports:
//   exe_*            ALU result, one cycle, never stalled, highest priority
//   lng_*            long result with valid/ready handshake
//   iss_long/iss_rd  issue of a long op; marks iss_rd pending
//   raddrN/rdenN/rdataN -> fdataN   decode operand forwarding
//   stall            decode reads a pending register
//   wren/waddr/wdata registered register-file write port
module writeback
    import writeback_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_valid,
    input  logic [REG_AW-1:0] exe_waddr,
    input  logic [DATA_W-1:0] exe_wdata,
    input  logic              lng_valid,
    input  logic [REG_AW-1:0] lng_waddr,
    input  logic [DATA_W-1:0] lng_wdata,
    output logic              lng_ready,
    input  logic              iss_long,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    input  logic              rden1,
    input  logic              rden2,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] fdata1,
    output logic [DATA_W-1:0] fdata2,
    output logic              stall,
    output logic              wren,
    output logic [REG_AW-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);

    wb_entry_t       exe_entry, lng_entry, head, sel;
    logic            fifo_empty, accept, push, pop, long_wr;
    register_in_type wb_d, wb_q;
    logic [31:0]     pend_d, pend_q;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (lng_entry),
        .dout  (head),
        .empty (fifo_empty),
        .avail (lng_ready)
    );

    always_comb begin
        exe_entry.waddr = exe_waddr;
        exe_entry.wdata = exe_wdata;
        lng_entry.waddr = lng_waddr;
        lng_entry.wdata = lng_wdata;
    end

    // Write-port arbitration: exe first, then FIFO head, then pass-through.
    // A long result is buffered whenever it cannot go straight to the port.
    always_comb begin
        accept  = lng_valid && lng_ready;
        push    = 1'b0;
        pop     = 1'b0;
        long_wr = 1'b0;
        sel     = lng_entry;
        wb_d    = wb_q;
        wb_d.wren = 1'b0;
        if (exe_valid) begin
            wb_d = wb_to_reg(exe_waddr != '0, exe_entry);
            push = accept;
        end else if (!fifo_empty) begin
            pop     = 1'b1;
            push    = accept;
            long_wr = 1'b1;
            sel     = head;
        end else if (accept) begin
            long_wr = 1'b1;
        end
        // x0 long results are still consumed, just never written.
        if (long_wr) wb_d = wb_to_reg(sel.waddr != '0, sel);
    end

    // Clear on the edge that loads the write port so decode sees the value
    // through forwarding in the same cycle the stall drops; set wins.
    always_comb begin
        pend_d = pend_q;
        if (long_wr) pend_d[sel.waddr] = 1'b0;
        if (iss_long && iss_rd != '0) pend_d[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q   <= '0;
            pend_q <= '0;
        end else begin
            wb_q   <= wb_d;
            pend_q <= pend_d;
        end
    end

    assign wren  = wb_q.wren;
    assign waddr = wb_q.waddr;
    assign wdata = wb_q.wdata;

    assign stall = (rden1 && pend_q[raddr1]) || (rden2 && pend_q[raddr2]);

    always_comb begin
        fdata1 = '0;
        fdata2 = '0;
        if (rden1) fdata1 = (wb_q.wren && wb_q.waddr == raddr1 && raddr1 != '0) ? wb_q.wdata
                                                                                 : rdata1;
        if (rden2) fdata2 = (wb_q.wren && wb_q.waddr == raddr2 && raddr2 != '0) ? wb_q.wdata
                                                                                 : rdata2;
    end

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;

    logic        clk, rst;
    logic        exe_valid, lng_valid, lng_ready, iss_long;
    logic [4:0]  exe_waddr, lng_waddr, iss_rd, raddr1, raddr2, waddr;
    logic [31:0] exe_wdata, lng_wdata, rdata1, rdata2, fdata1, fdata2, wdata;
    logic        rden1, rden2, stall, wren;

    int total = 0;
    int bad   = 0;

    // Hand-computed table for the FIFO back-pressure sequence.
    logic        exp_rdy [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0]  exp_wa  [7] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd20, 5'd21, 5'd22};
    logic [31:0] exp_wd  [7] = '{32'h100, 32'h101, 32'h102, 32'h103,
                                 32'h200, 32'h201, 32'h202};
    logic [4:0]  lng_a   [7] = '{5'd20, 5'd21, 5'd22, 5'd22, 5'd22, 5'd22, 5'd0};

    writeback #(.FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .exe_valid (exe_valid),
        .exe_waddr (exe_waddr),
        .exe_wdata (exe_wdata),
        .lng_valid (lng_valid),
        .lng_waddr (lng_waddr),
        .lng_wdata (lng_wdata),
        .lng_ready (lng_ready),
        .iss_long  (iss_long),
        .iss_rd    (iss_rd),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .rden1     (rden1),
        .rden2     (rden2),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .fdata1    (fdata1),
        .fdata2    (fdata2),
        .stall     (stall),
        .wren      (wren),
        .waddr     (waddr),
        .wdata     (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exe_valid = 0; exe_waddr = 0; exe_wdata = 0;
        lng_valid = 0; lng_waddr = 0; lng_wdata = 0;
        iss_long  = 0; iss_rd    = 0;
    endtask

    initial begin
        rst = 0;
        idle();
        raddr1 = 0; raddr2 = 0; rden1 = 0; rden2 = 0; rdata1 = 0; rdata2 = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wren", 32'(wren), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        rden1 = 1; raddr1 = 7; rden2 = 1; raddr2 = 3; #1;
        chk("rst_stall", 32'(stall), 32'd0);
        rden1 = 0; rden2 = 0;
        rst = 1;
        tick();
        chk("ready_after_release", 32'(lng_ready), 32'd1);

        // Basic exe write and forwarding
        exe_valid = 1; exe_waddr = 5; exe_wdata = 32'h1234;
        tick();
        idle();
        rden1 = 1; raddr1 = 5; rdata1 = 32'hdead;
        rden2 = 0; raddr2 = 5; rdata2 = 32'h5555; #1;
        chk("exe_wren", 32'(wren), 32'd1);
        chk("exe_waddr", 32'(waddr), 32'd5);
        chk("exe_wdata", wdata, 32'h1234);
        chk("fwd_fdata1", fdata1, 32'h1234);
        chk("rden2_off_fdata2", fdata2, 32'd0);
        raddr1 = 6; #1;
        chk("nofwd_fdata1", fdata1, 32'hdead);
        rden1 = 0;

        // Same-cycle exe and long: exe first, long one cycle later
        exe_valid = 1; exe_waddr = 3; exe_wdata = 32'hA;
        lng_valid = 1; lng_waddr = 4; lng_wdata = 32'hB;
        tick();
        idle();
        chk("same_x3_addr", 32'(waddr), 32'd3);
        chk("same_x3_data", wdata, 32'hA);
        tick();
        chk("same_x4_wren", 32'(wren), 32'd1);
        chk("same_x4_addr", 32'(waddr), 32'd4);
        chk("same_x4_data", wdata, 32'hB);
        tick();
        chk("same_idle_wren", 32'(wren), 32'd0);
        chk("same_ready", 32'(lng_ready), 32'd1);

        // Back-pressure: exe busy 4 cycles, 3 long results, depth 2
        for (int i = 0; i < 7; i++) begin
            exe_valid = (i < 4);
            exe_waddr = 5'(10 + i);
            exe_wdata = 32'h100 + 32'(i);
            lng_valid = (i < 6);
            lng_waddr = lng_a[i];
            lng_wdata = 32'h200 + 32'(lng_a[i]) - 32'd20;
            #1;
            chk($sformatf("bp_ready_c%0d", i), 32'(lng_ready), 32'(exp_rdy[i]));
            tick();
            chk($sformatf("bp_wren_c%0d", i), 32'(wren), 32'd1);
            chk($sformatf("bp_waddr_c%0d", i), 32'(waddr), 32'(exp_wa[i]));
            chk($sformatf("bp_wdata_c%0d", i), wdata, exp_wd[i]);
        end
        idle();
        tick();
        chk("bp_drained_wren", 32'(wren), 32'd0);
        chk("bp_drained_ready", 32'(lng_ready), 32'd1);

        // Scoreboard stall on pending x7
        iss_long = 1; iss_rd = 7;
        tick();
        idle();
        rden1 = 1; raddr1 = 7; rdata1 = 32'h1111; #1;
        chk("sb_stall_set", 32'(stall), 32'd1);
        tick();
        chk("sb_stall_hold", 32'(stall), 32'd1);
        lng_valid = 1; lng_waddr = 7; lng_wdata = 32'h77; #1;
        chk("sb_stall_accept_cycle", 32'(stall), 32'd1);
        tick();
        idle(); #1;
        chk("sb_write_addr", 32'(waddr), 32'd7);
        chk("sb_stall_cleared", 32'(stall), 32'd0);
        chk("sb_fwd_fdata1", fdata1, 32'h77);
        iss_long = 1; iss_rd = 7;
        tick();
        idle(); #1;
        chk("sb_stall_reset", 32'(stall), 32'd1);
        lng_valid = 1; lng_waddr = 7; lng_wdata = 32'h78;
        iss_long = 1; iss_rd = 7;
        tick();
        idle(); #1;
        chk("sb_setwins_data", wdata, 32'h78);
        chk("sb_setwins_stall", 32'(stall), 32'd1);
        lng_valid = 1; lng_waddr = 7; lng_wdata = 32'h79;
        tick();
        idle(); #1;
        chk("sb_final_clear", 32'(stall), 32'd0);
        rden1 = 0;

        // x0 writes are dropped; long x0 still consumed
        exe_valid = 1; exe_waddr = 0; exe_wdata = 32'hFFFFFFFF;
        tick();
        idle();
        rden1 = 1; raddr1 = 0; rdata1 = 32'hCAFE; #1;
        chk("x0_exe_wren", 32'(wren), 32'd0);
        chk("x0_fdata1", fdata1, 32'hCAFE);
        rden1 = 0;
        exe_valid = 1; exe_waddr = 9; exe_wdata = 32'h9;
        lng_valid = 1; lng_waddr = 0; lng_wdata = 32'h55;
        tick();
        idle();
        chk("x0_exe9_addr", 32'(waddr), 32'd9);
        tick();
        chk("x0_lng_wren", 32'(wren), 32'd0);
        tick();
        chk("x0_lng_popped_ready", 32'(lng_ready), 32'd1);

        // Reset mid-drain with 2 buffered entries and 3 pending bits
        for (int i = 1; i <= 3; i++) begin
            iss_long = 1; iss_rd = 5'(i);
            tick();
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            exe_valid = 1; exe_waddr = 5'(12 + i); exe_wdata = 32'h300 + 32'(i);
            lng_valid = 1; lng_waddr = 5'(20 + i); lng_wdata = 32'h400 + 32'(i); #1;
            chk($sformatf("fill_ready_%0d", i), 32'(lng_ready), 32'd1);
            tick();
        end
        idle();
        exe_valid = 1; exe_waddr = 14; exe_wdata = 32'h314; #1;
        chk("fill_full_ready", 32'(lng_ready), 32'd0);
        tick();
        idle();
        #2 rst = 0;
        #1;
        chk("rst_async_wren", 32'(wren), 32'd0);
        tick();
        tick();
        rst = 1;
        tick();
        chk("rel_ready", 32'(lng_ready), 32'd1);
        chk("rel_wren_0", 32'(wren), 32'd0);
        rden1 = 1; raddr1 = 1; rden2 = 1; raddr2 = 3; #1;
        chk("rel_stall", 32'(stall), 32'd0);
        tick();
        chk("rel_wren_1", 32'(wren), 32'd0);
        tick();
        chk("rel_wren_2", 32'(wren), 32'd0);
        rden1 = 0; rden2 = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
